// File: rtl/if_pkg.sv
// Shared types and constants for the MIPS instruction-fetch stage.
package if_pkg;

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } if_state_e;

  localparam int BYTE_SIZE = 8;

  // Wide enough for any instruction width up to 8 bytes; modules slice it down.
  localparam logic [63:0] DEF_HALT_WORD = '1;

  // Index width for a power-of-two depth, never narrower than one bit.
  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/if_fetch_queue.sv
// Prefetch FIFO of {PC, instruction} entries; flush empties it and wins over push.
module if_fetch_queue
  import if_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int PC_W   = 32,
  parameter int DATA_W = 32,
  localparam int AW    = idx_width(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [PC_W-1:0]   push_pc,
  input  logic [DATA_W-1:0] push_instr,
  output logic [CW-1:0]     count,
  output logic [PC_W-1:0]   head_pc,
  output logic [DATA_W-1:0] head_instr
);

  logic [PC_W+DATA_W-1:0] entries [DEPTH];
  logic [AW-1:0]          rd_ptr;
  logic [AW-1:0]          wr_ptr;
  logic                   do_pop;
  logic                   do_push;

  // Pushing into a full queue is legal when the head leaves in the same cycle.
  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count < CW'(DEPTH)) || do_pop);

  always_ff @(posedge i_clk) begin
    if (do_push && !flush) begin
      entries[wr_ptr] <= {push_pc, push_instr};
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  assign {head_pc, head_instr} = entries[rd_ptr];

endmodule

// File: rtl/if_prefetch.sv
// Instruction-fetch stage: loadable program memory, PC-tagged prefetch queue, redirect flush.
// Optional IF_HALT_DETECT_EN: stop fetching on a halt word and halt once decode pops it.
module if_prefetch
  import if_pkg::*;
#(
  parameter int PC_SIZE            = 32,
  parameter int WORD_SIZE_IN_BYTES = 4,
  parameter int MEM_SIZE_IN_WORDS  = 64,
  parameter int QUEUE_DEPTH        = 4,
  parameter logic [BYTE_SIZE*WORD_SIZE_IN_BYTES-1:0] HALT_WORD =
    DEF_HALT_WORD[BYTE_SIZE*WORD_SIZE_IN_BYTES-1:0],
  localparam int BUS_SIZE = BYTE_SIZE * WORD_SIZE_IN_BYTES
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_write_mem,
  input  logic [BUS_SIZE-1:0] i_instruction,
  input  logic                i_start,
  input  logic                i_redirect,
  input  logic [PC_SIZE-1:0]  i_redirect_pc,
  input  logic                i_ready,
  output logic                o_full_mem,
  output logic                o_empty_mem,
  output logic                o_valid,
  output logic [BUS_SIZE-1:0] o_instruction,
  output logic [PC_SIZE-1:0]  o_pc,
  output logic [PC_SIZE-1:0]  o_next_seq_pc,
  output logic                o_halted,
  output if_state_e           o_state
);

  localparam int MEM_AW = idx_width(MEM_SIZE_IN_WORDS);
  localparam int WP_W   = MEM_AW + 1;
  localparam int OFS_W  = $clog2(WORD_SIZE_IN_BYTES);
  localparam int QCW    = idx_width(QUEUE_DEPTH) + 1;

  if_state_e           state;
  logic [PC_SIZE-1:0]  pc;
  logic [WP_W-1:0]     wp;
  logic                fetch_stop;
  logic                rd_valid;
  logic [PC_SIZE-1:0]  rd_pc;
  logic                rd_oob;
  logic [BUS_SIZE-1:0] rd_data;
  logic [BUS_SIZE-1:0] mem [MEM_SIZE_IN_WORDS];

  logic [PC_SIZE-1:0]  mem_idx;
  logic                load_wr;
  logic                issue;
  logic                push;
  logic                pop;
  logic                flush;
  logic                halt_pop;
  logic                stop_set;
  logic [BUS_SIZE-1:0] push_word;
  logic [QCW-1:0]      q_count;
  logic [PC_SIZE-1:0]  q_head_pc;
  logic [BUS_SIZE-1:0] q_head_instr;

  assign mem_idx     = pc >> OFS_W;
  assign o_full_mem  = (wp == WP_W'(MEM_SIZE_IN_WORDS));
  assign o_empty_mem = (wp == '0);
  assign load_wr     = (state == ST_LOAD) && i_write_mem && !o_full_mem;

  // Queue slots are reserved at issue time, so the read in flight counts as occupied.
  assign issue = (state == ST_RUN) && !fetch_stop && !i_redirect &&
                 ((int'(q_count) + int'(rd_valid)) < QUEUE_DEPTH);
  assign push      = rd_valid && (state == ST_RUN) && !i_redirect;
  assign push_word = rd_oob ? HALT_WORD : rd_data;

  // Handshake: an entry retires on a rising edge where o_valid && i_ready; while
  // o_valid is high and i_ready low, the head entry and its outputs hold steady.
  assign pop   = o_valid && i_ready;

`ifdef IF_HALT_DETECT_EN
  assign stop_set = push && (push_word == HALT_WORD);
  assign halt_pop = pop && !i_redirect && (q_head_instr == HALT_WORD);
  assign o_halted = (state == ST_HALTED);
`else
  assign stop_set = 1'b0;
  assign halt_pop = 1'b0;
  assign o_halted = 1'b0;
`endif

  assign flush = i_redirect || halt_pop;

  always_ff @(posedge i_clk) begin
    if (load_wr) mem[wp[MEM_AW-1:0]] <= i_instruction;
    rd_data <= mem[mem_idx[MEM_AW-1:0]];
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state      <= ST_LOAD;
      pc         <= '0;
      wp         <= '0;
      fetch_stop <= 1'b0;
      rd_valid   <= 1'b0;
      rd_pc      <= '0;
      rd_oob     <= 1'b0;
    end else begin
      rd_valid <= issue;
      if (issue) begin
        rd_pc  <= pc;
        rd_oob <= (mem_idx >= PC_SIZE'(wp));
        pc     <= pc + PC_SIZE'(WORD_SIZE_IN_BYTES);
      end
      if (stop_set) fetch_stop <= 1'b1;
      case (state)
        ST_LOAD: begin
          if (load_wr) wp <= wp + WP_W'(1);
          if (i_start && !o_empty_mem) begin
            state      <= ST_RUN;
            pc         <= '0;
            fetch_stop <= 1'b0;
          end
        end
        ST_RUN: begin
          if (i_redirect) begin
            pc         <= i_redirect_pc & ~PC_SIZE'(WORD_SIZE_IN_BYTES - 1);
            fetch_stop <= 1'b0;
          end else if (halt_pop) begin
            state <= ST_HALTED;
          end
        end
        ST_HALTED: state <= ST_HALTED;
        default:   state <= ST_LOAD;
      endcase
    end
  end

  if_fetch_queue #(
    .DEPTH  (QUEUE_DEPTH),
    .PC_W   (PC_SIZE),
    .DATA_W (BUS_SIZE)
  ) u_queue (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .push       (push),
    .pop        (pop),
    .flush      (flush),
    .push_pc    (rd_pc),
    .push_instr (push_word),
    .count      (q_count),
    .head_pc    (q_head_pc),
    .head_instr (q_head_instr)
  );

  // Idle head outputs read as zero so reset and empty look identical to decode.
  assign o_valid       = (state == ST_RUN) && (q_count != '0);
  assign o_instruction = o_valid ? q_head_instr : '0;
  assign o_pc          = o_valid ? q_head_pc : '0;
  assign o_next_seq_pc = o_pc + PC_SIZE'(WORD_SIZE_IN_BYTES);
  assign o_state       = state;

endmodule

// File: tb/tb_if_prefetch.sv
// Bench for if_prefetch: directed timing steps plus random ready/redirect traffic
// checked against a program-order model of the instruction stream.
module tb_if_prefetch;

  localparam logic [31:0] HALT = 32'hFFFF_FFFF;
`ifdef IF_HALT_DETECT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b0;
  logic        i_write_mem = 1'b0;
  logic [31:0] i_instruction = '0;
  logic        i_start = 1'b0;
  logic        i_redirect = 1'b0;
  logic [31:0] i_redirect_pc = '0;
  logic        i_ready = 1'b0;
  logic        o_full_mem;
  logic        o_empty_mem;
  logic        o_valid;
  logic [31:0] o_instruction;
  logic [31:0] o_pc;
  logic [31:0] o_next_seq_pc;
  logic        o_halted;
  logic [1:0]  o_state;

  // ---------------- clock / reset ----------------
  always #5 i_clk = ~i_clk;

  if_prefetch dut (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_write_mem   (i_write_mem),
    .i_instruction (i_instruction),
    .i_start       (i_start),
    .i_redirect    (i_redirect),
    .i_redirect_pc (i_redirect_pc),
    .i_ready       (i_ready),
    .o_full_mem    (o_full_mem),
    .o_empty_mem   (o_empty_mem),
    .o_valid       (o_valid),
    .o_instruction (o_instruction),
    .o_pc          (o_pc),
    .o_next_seq_pc (o_next_seq_pc),
    .o_halted      (o_halted),
    .o_state       (o_state)
  );

  initial begin
    #500000;
    $display("FAIL timeout: run did not finish, observed no end, expected end of stimulus");
    $fatal(1, "timeout");
  end

  // ---------------- scoreboard / model ----------------
  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_q[$];      // program as loaded; index = word address
  logic [31:0] exp_pc;        // PC decode must see next
  bit          model_halted;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] word_at(input logic [31:0] pc);
    int unsigned idx;
    idx = pc >> 2;
    return (idx < exp_q.size()) ? exp_q[idx] : HALT;
  endfunction

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom();
    if (w == HALT) w = 32'h0;
    return w;
  endfunction

  // ---------------- driver tasks ----------------
  // Called at a falling edge: compare the head, drive inputs, advance one cycle.
  task automatic step(input bit rdy, input bit redir, input logic [31:0] rpc);
    bit          popped_halt;
    logic [31:0] nxt;
    popped_halt   = 1'b0;
    i_ready       = rdy;
    i_redirect    = redir;
    i_redirect_pc = rpc;
    if (model_halted) begin
      check("halted_no_valid", o_valid, 1'b0);
    end else if (o_valid) begin
      nxt = exp_pc + 32'd4;
      check("head_pc", o_pc, exp_pc);
      check("head_instr", o_instruction, word_at(exp_pc));
      check("next_seq_pc", o_next_seq_pc, nxt);
      if (rdy) begin
        popped_halt = (word_at(exp_pc) == HALT) && !redir;
        exp_pc = nxt;
      end
    end
    if (redir && !model_halted) exp_pc = rpc & ~32'd3;
    @(negedge i_clk);
    i_redirect = 1'b0;
    if (popped_halt) begin
      check("halt_flag_after_pop", o_halted, HALT_EN);
      model_halted = HALT_EN;
    end
  endtask

  task automatic load_word(input logic [31:0] w);
    i_write_mem   = 1'b1;
    i_instruction = w;
    step(1'b0, 1'b0, '0);
    i_write_mem   = 1'b0;
    if (exp_q.size() < 64) exp_q.push_back(w);
  endtask

  task automatic start_run();
    i_start      = 1'b1;
    exp_pc       = '0;
    model_halted = 1'b0;
    step(1'b0, 1'b0, '0);
    i_start      = 1'b0;
  endtask

  // Asserts reset between clock edges so its effect is seen without any edge.
  task automatic apply_reset();
    @(negedge i_clk);
    #2;
    i_reset     = 1'b0;
    i_write_mem = 1'b0;
    i_start     = 1'b0;
    i_redirect  = 1'b0;
    i_ready     = 1'b0;
    #1;
    check("rst_valid", o_valid, 1'b0);
    check("rst_instr", o_instruction, 32'h0);
    check("rst_pc", o_pc, 32'h0);
    check("rst_next_seq_pc", o_next_seq_pc, 32'h4);
    check("rst_halted", o_halted, 1'b0);
    check("rst_empty", o_empty_mem, 1'b1);
    check("rst_full", o_full_mem, 1'b0);
    @(negedge i_clk);
    i_reset = 1'b1;
    exp_q.delete();
    exp_pc       = '0;
    model_halted = 1'b0;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int seen_fc;
    apply_reset();

    // start with nothing loaded is ignored
    i_start = 1'b1;
    step(1'b1, 1'b0, '0);
    i_start = 1'b0;
    repeat (3) step(1'b1, 1'b0, '0);
    check("empty_start_valid", o_valid, 1'b0);
    check("empty_start_empty", o_empty_mem, 1'b1);

    // three-word program ending in a halt word, decode always ready
    load_word(32'h2001_0005);
    check("empty_after_write", o_empty_mem, 1'b0);
    check("full_after_write", o_full_mem, 1'b0);
    load_word(32'h2002_0003);
    load_word(HALT);
    i_start      = 1'b1;
    exp_pc       = '0;
    model_halted = 1'b0;
    step(1'b1, 1'b0, '0);
    i_start = 1'b0;
    check("start_lat_n", o_valid, 1'b0);
    step(1'b1, 1'b0, '0);
    check("start_lat_n1", o_valid, 1'b0);
    step(1'b1, 1'b0, '0);
    check("start_lat_n2", o_valid, 1'b1);
    check("first_pc", o_pc, 32'h0);
    step(1'b1, 1'b0, '0);
    check("seq_pc4", o_pc, 32'h4);
    step(1'b1, 1'b0, '0);
    check("seq_pc8", o_pc, 32'h8);
    repeat (4) step(1'b1, 1'b0, '0);

    // backpressure, then redirect to an unaligned target
    apply_reset();
    for (int i = 0; i < 8; i++) load_word(rand_word());
    start_run();
    repeat (10) step(1'b0, 1'b0, '0);
    check("stall_head_pc", o_pc, 32'h0);
    step(1'b1, 1'b0, '0);
    repeat (3) step(1'b0, 1'b0, '0);
    check("pre_redirect_head", o_pc, 32'h4);
    step(1'b0, 1'b1, 32'h0000_000E);
    check("redir_lat_n", o_valid, 1'b0);
    step(1'b0, 1'b0, '0);
    check("redir_lat_n1", o_valid, 1'b0);
    step(1'b0, 1'b0, '0);
    check("redir_lat_n2", o_valid, 1'b1);
    check("redir_target_pc", o_pc, 32'hC);
    repeat (8) step(1'b0, 1'b0, '0);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, '0);
      check("release_no_gap", o_valid, 1'b1);
    end
    repeat (6) step(1'b1, 1'b0, '0);

    // redirect over a queued halt word
    apply_reset();
    load_word(rand_word());
    load_word(rand_word());
    load_word(HALT);
    start_run();
    repeat (8) step(1'b0, 1'b0, '0);
    step(1'b0, 1'b1, 32'h4);
    step(1'b0, 1'b0, '0);
    step(1'b0, 1'b0, '0);
    check("halt_redir_valid", o_valid, 1'b1);
    check("halt_redir_pc", o_pc, 32'h4);
    check("halt_redir_not_halted", o_halted, 1'b0);
    repeat (6) step(1'b1, 1'b0, '0);

    // full memory; extra write ignored
    apply_reset();
    for (int i = 0; i < 64; i++) load_word(rand_word());
    check("full_at_64", o_full_mem, 1'b1);
    check("not_empty_at_64", o_empty_mem, 1'b0);
    load_word(32'h1234_5678);
    check("full_after_65th", o_full_mem, 1'b1);
    start_run();
    seen_fc = 0;
    for (int i = 0; i < 72; i++) begin
      if (o_valid && o_pc == 32'hFC) begin
        check("pc_fc_word63", o_instruction, exp_q[63]);
        seen_fc++;
      end
      step(1'b1, 1'b0, '0);
    end
    check("pc_fc_seen", seen_fc, 1);

    // random ready and redirect traffic
    apply_reset();
    for (int i = 0; i < 16; i++) load_word(rand_word());
    start_run();
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0),
           32'($urandom_range(0, 63)));
    end

    // reset in the middle of a run, then start with an empty memory
    apply_reset();
    for (int i = 0; i < 4; i++) load_word(rand_word());
    start_run();
    repeat (6) step(1'b0, 1'b0, '0);
    check("midrun_valid_before_reset", o_valid, 1'b1);
    apply_reset();
    i_start = 1'b1;
    step(1'b1, 1'b0, '0);
    i_start = 1'b0;
    repeat (4) step(1'b1, 1'b0, '0);
    check("post_reset_start_valid", o_valid, 1'b0);
    check("post_reset_start_empty", o_empty_mem, 1'b1);
    check("post_reset_halted", o_halted, 1'b0);

    // ---------------- report ----------------
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
